// File: rtl/mandel_iterator_pm_if.sv
// Point-in / result-out bundle between the dispatcher and one Mandelbrot iterator.
interface mandel_iterator_pm_if #(
    parameter int W      = 27,
    parameter int ITER_W = 16,
    parameter int TAG_W  = 20
);
    logic              flush;
    logic              in_val;
    logic              in_rdy;
    logic [W-1:0]      in_c_r;
    logic [W-1:0]      in_c_i;
    logic [ITER_W-1:0] in_max_iter;
    logic [TAG_W-1:0]  in_tag;
    logic              out_val;
    logic              out_rdy;
    logic [ITER_W-1:0] out_iter;
    logic              out_escaped;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport slave (
        input  flush, in_val, in_c_r, in_c_i, in_max_iter, in_tag, out_rdy,
        output in_rdy, out_val, out_iter, out_escaped, out_tag, busy
    );

    modport master (
        output flush, in_val, in_c_r, in_c_i, in_max_iter, in_tag, out_rdy,
        input  in_rdy, out_val, out_iter, out_escaped, out_tag, busy
    );
endinterface

// File: rtl/mandel_iterator_pm.sv
// Mandelbrot escape-time engine: one z <- z^2 + c step per clock in signed Q(W-F).F,
// with per-point iteration limit, pass-through tag, flush and back-to-back result drain.
module mandel_iterator_pm #(
    parameter int W      = 27,
    parameter int F      = 23,
    parameter int ITER_W = 16,
    parameter int TAG_W  = 20
) (
    input logic                 clk,
    input logic                 reset_n,
    mandel_iterator_pm_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic signed [W+1:0] TWO_Q  = {{(W-F){1'b0}}, 1'b1, {(F+1){1'b0}}};
    localparam logic signed [W:0]   FOUR_Q = {{(W-F-2){1'b0}}, 1'b1, {(F+2){1'b0}}};

    // Full 2W-bit signed product shifted right by F (floor); |z| <= 2 keeps it in W+1 bits.
    function automatic logic signed [W:0] mul_q(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = a * b;
        return (W+1)'(p >>> F);
    endfunction

    function automatic logic signed [W+1:0] ext2(input logic signed [W:0] v);
        return {v[W], v};
    endfunction

    state_t state, state_nxt;

    logic signed [W-1:0] c_r, c_i, zr, zi;
    logic [TAG_W-1:0]    tag, out_tag_q;
    logic [ITER_W-1:0]   lim, k, k_inc, out_iter_q;
    logic                out_escaped_q;

    logic signed [W:0]   zr2, zi2, x, mag;
    logic signed [W+1:0] zr_nxt, zi_nxt;
    logic                esc_mag, esc_z, hit_lim;
    logic                rdy, accept, finish, step;

    always_comb begin
        zr2     = mul_q(zr, zr);
        zi2     = mul_q(zi, zi);
        x       = mul_q(zr, zi);
        mag     = zr2 + zi2;
        zr_nxt  = ext2(zr2) - ext2(zi2) + signed'({{2{c_r[W-1]}}, c_r});
        zi_nxt  = signed'({x, 1'b0}) + signed'({{2{c_i[W-1]}}, c_i});
        k_inc   = k + ITER_W'(1);
        esc_mag = mag > FOUR_Q;
        esc_z   = (zr_nxt > TWO_Q) || (zr_nxt < -TWO_Q) ||
                  (zi_nxt > TWO_Q) || (zi_nxt < -TWO_Q);
        hit_lim = k_inc == lim;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        rdy             = (state == IDLE) || (state == DONE && bus.out_rdy);
        accept          = bus.in_val && rdy && !bus.flush;
        finish          = (state == CALC) && !bus.flush && (esc_mag || esc_z || hit_lim);
        step            = (state == CALC) && !bus.flush && !finish;
        bus.in_rdy      = rdy;
        bus.out_val     = (state == DONE);
        bus.busy        = (state != IDLE);
        bus.out_iter    = out_iter_q;
        bus.out_escaped = out_escaped_q;
        bus.out_tag     = out_tag_q;
        state_nxt       = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = CALC;
                CALC:    if (finish) state_nxt = DONE;
                DONE:    if (bus.out_rdy) state_nxt = accept ? CALC : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Point latch / iterate / result capture. A step that overshoots is never stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_r           <= '0;
            c_i           <= '0;
            zr            <= '0;
            zi            <= '0;
            tag           <= '0;
            lim           <= '0;
            k             <= '0;
            out_iter_q    <= '0;
            out_escaped_q <= 1'b0;
            out_tag_q     <= '0;
        end else begin
            if (accept) begin
                c_r <= bus.in_c_r;
                c_i <= bus.in_c_i;
                tag <= bus.in_tag;
                lim <= (bus.in_max_iter == '0) ? ITER_W'(1) : bus.in_max_iter;
                zr  <= '0;
                zi  <= '0;
                k   <= '0;
            end else if (step) begin
                zr <= zr_nxt[W-1:0];
                zi <= zi_nxt[W-1:0];
                k  <= k_inc;
            end
            if (finish) begin
                out_iter_q    <= esc_mag ? k : (esc_z ? k_inc : lim);
                out_escaped_q <= esc_mag || esc_z;
                out_tag_q     <= tag;
            end
        end
    end

endmodule

// File: doc/mandel_iterator_pm.md
Name: mandel_iterator_pm

Overview:
- Parametrised next-generation Mandelbrot escape-time engine. Iterates z <- z^2 + c, one iteration per clock, in signed Q(W-F).F fixed point.
- Compared with the current fixed iterator it adds:
  - a runtime per-point iteration limit;
  - a pixel tag carried through to the output;
  - an escaped/in-set flag;
  - a flush;
  - back-to-back accept on result drain.
- Sits between the pixel-coordinate generator and the colour-map/VGA-buffer writer; several instances are tiled by the dispatcher.

Parameters:
- W, 27, total fixed-point width of c and z (signed two's complement).
- F, 23, fractional bits; W-F >= 4 required (integer range +/-8).
- ITER_W, 16, width of iteration limit and count.
- TAG_W, 20, width of opaque pixel tag.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; drops the in-flight point.
- in_val  in  1  input point valid.
- in_rdy  out  1  engine can accept a point this cycle.
- in_c_r  in  W  real part of c, signed QF.
- in_c_i  in  W  imaginary part of c, signed QF.
- in_max_iter  in  ITER_W  iteration limit for this point; 0 is treated as 1.
- in_tag  in  TAG_W  pixel tag.
- out_val  out  1  result valid.
- out_rdy  in  1  consumer accepts result.
- out_iter  out  ITER_W  iterations executed.
- out_escaped  out  1  1 = point escaped; 0 = limit reached.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; reset_n asynchronous active-low, sampled into all state flops.
- Reset values: state=IDLE; in_rdy=1; out_val=0; busy=0; out_iter=0; out_escaped=0; out_tag=0; z registers=0.
- States:
  - IDLE: accept point.
  - CALC: iterate.
  - DONE: hold result.
- Outputs by state:
  - in_rdy = (state==IDLE) || (state==DONE && out_rdy).
  - out_val = (state==DONE).
  - All outputs are driven from registers or state decode only; no input-to-output combinational path except in_rdy from out_rdy.
- Accept (in_val && in_rdy) at edge t:
  - latch c, tag, and lim = max(in_max_iter,1);
  - clear zr, zi and count k;
  - go to CALC.
- CALC cycle k -> k+1, from z_k:
  - zr2 = (zr*zr)>>>F, zi2 = (zi*zi)>>>F, x = (zr*zi)>>>F. Full 2W-bit signed products, arithmetic shift, truncation toward -inf.
  - zr' = zr2 - zi2 + c_r and zi' = 2x + c_i, computed in W+2 bits; the low W bits are registered.
  - mag = zr2 + zi2, in W+1 bits.
- Termination, evaluated in the same cycle as the step:
  - A. mag > 4.0 (4<<F): escape, out_iter = k; z' discarded.
  - B. Else |zr'| > 2.0 or |zi'| > 2.0, compared in W+2 bits: escape, out_iter = k+1.
  - C. Else k+1 == lim: out_iter = lim, out_escaped = 0.
  - D. Else z <= z', k <= k+1, stay in CALC.
  - Priority is A > B > C; an escape on the limit step reports escaped=1.
- Latency: on any termination, state moves to DONE at the next edge. Outputs are registered at that edge.
- Cycle count: a point accepted at edge t that terminates at step n asserts out_val at edge t+n (n >= 1).
- DONE:
  - Holds out_* stable until out_rdy.
  - On out_rdy, if in_val is also high: new point accepted, state -> CALC, with no IDLE bubble.
  - On out_rdy without in_val: -> IDLE.
- flush:
  - Forces IDLE at the next edge from any state; out_val drops and the result is lost.
  - Any accept in the same cycle is ignored; in_rdy is still 1 but flush wins.
- Asynchronous reset mid-CALC or mid-DONE: immediate return to reset values; no output produced.
- Inputs are ignored while in CALC, even if in_val is held high.
- Overflow: z magnitudes <= 2 entering a step keep every intermediate within W+2 bits, so no saturation logic is required.

Test Plan:
- T1 reset/idle: assert reset_n=0 mid-CALC -> out_val=0, in_rdy=1, busy=0 immediately; no stale result after release.
- T2 c=0+0i, max_iter=10, tag=0x123 -> out_val exactly 10 cycles after accept; out_iter=10, out_escaped=0, out_tag=0x123.
- T3 escape cases, each with max_iter=1000:
  - c=2.0+0i -> out_iter=2, escaped=1 (rule B at step 2);
  - c=1.0+1.0i -> out_iter=2, escaped=1 (zi=3.0);
  - c=-2.0+0i -> out_iter=1000, escaped=0.
- T4 limit edges:
  - max_iter=0 with c=0 -> out_iter=1, escaped=0;
  - c=2.0+0i with max_iter=2 -> out_iter=2, escaped=1 (escape beats limit).
- T5 handshake:
  - hold out_rdy=0 for 20 cycles -> outputs stable, in_rdy=0;
  - then out_rdy=1 with in_val=1 -> next point accepted the same cycle, CALC next edge, back-to-back throughput check over 50 random points against a bit-accurate software model.
- T6 flush:
  - flush during CALC step 5 -> IDLE next edge, no out_val;
  - flush in DONE -> result dropped;
  - flush coincident with in_val -> point not accepted.
